dcache: RTL
===========

Name: dcache

Overview:
- Direct-mapped, write-back, write-allocate L1 data cache between the MEM-stage data-memory interface and physical memory.
- It consumes the MEM-stage request signals: stb/cyc, write, byte enable, address and write data.
- It returns dmem_rdata/dmem_resp and refills or evicts 128-bit lines over a pmem handshake.

Parameters:
- NUM_SETS, 8, number of lines; power of two; index width = log2(NUM_SETS).
- LINE_BYTES, 16, bytes per line (8 words); fixes offset width at 4.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- dmem_action_stb  in  1  request strobe.
- dmem_action_cyc  in  1  bus cycle; a request is valid only when stb and cyc are both high.
- dmem_write  in  1  1 = store, 0 = load.
- dmem_byte_enable  in  2  01 = low byte, 10 = high byte, 11 = word.
- dmem_address  in  16  byte address; bit 0 ignored for word selection.
- dmem_wdata  in  16  store data; byte lanes are already positioned.
- dmem_rdata  out  16  load data; valid while dmem_resp is high.
- dmem_resp  out  1  single-cycle completion pulse per request.
- pmem_address  out  16  line-aligned address; bits [3:0] = 0.
- pmem_read  out  1  line fill request; held high until pmem_resp.
- pmem_write  out  1  line writeback request; held high until pmem_resp.
- pmem_wdata  out  128  evicted line data.
- pmem_rdata  in  128  fill data; sampled on pmem_resp.
- pmem_resp  in  1  pmem transaction complete.

Behaviour:
- Address split: offset [3:0], word select [3:1], index [3+log2(NUM_SETS):4], tag = remaining upper bits.
- Per-set state: valid, dirty, tag and a 128-bit line, all flops.
- Hit = valid[index] && tag match.
- Reset values: all valid and dirty bits = 0, FSM = IDLE, pmem_read = pmem_write = 0.
- dmem_resp is forced to 0 while reset is high.
- dmem_rdata = 0 whenever dmem_resp = 0.
- FSM states:
  - IDLE:
    - Valid request and hit: dmem_resp = 1 combinationally in the same cycle. Loads drive the selected word.
    - Store hit: merge the enabled bytes into the line at the clock edge and set dirty.
    - Valid request, miss, dirty victim: go to WRITEBACK.
    - Valid request, miss, clean or invalid victim: go to FILL.
  - WRITEBACK:
    - pmem_write = 1, pmem_address = {victim tag, index, 4'b0}, pmem_wdata = victim line.
    - On pmem_resp: clear dirty, then go to FILL. If the request is no longer valid, return to IDLE instead.
  - FILL:
    - pmem_read = 1, pmem_address = {request tag, index, 4'b0}.
    - On pmem_resp: install the line, set valid, clear dirty, write the tag, return to IDLE.
    - The retried request then hits in the next cycle.
- Latency:
  - Hit: 0 cycles (response in the request cycle).
  - Clean miss: fill cycles + 1.
  - Dirty miss: writeback cycles + fill cycles + 1.
- dmem_resp is never asserted in WRITEBACK or FILL.
- Request withdrawn (cyc/stb low, e.g. pipeline flush) mid-miss:
  - A started pmem transaction is always completed; the pmem handshake is never abandoned.
  - A fill still installs the line.
  - No dmem_resp is generated.
- Request signals changing mid-miss: the FSM re-evaluates hit/miss in IDLE against the current request; no request state is latched.
- pmem_read and pmem_write are never high together.
- pmem_read/pmem_write drop in the cycle after pmem_resp.
- Reset mid-miss: the FSM returns to IDLE at the edge and all lines are invalidated, dirty data included. The pmem side is reset in the same cycle.
- Byte merge:
  - 01 writes bits [7:0] of the selected word.
  - 10 writes bits [15:8].
  - 11 writes the full word.
  - 00 is treated as a no-op store that still responds.

Decomposition:
- Add to lc3b_types:
  - lc3b_cache_line (logic [127:0]).
  - lc3b_c_offset (4 bits), lc3b_c_index and lc3b_c_tag, widths derived from the default NUM_SETS.
  - A typedef enum for the dcache states {IDLE, WRITEBACK, FILL}.
- One natural sub-module, dcache_control: the FSM producing pmem_read, pmem_write, a load_line strobe, a clear_dirty strobe and the pmem address-select signal.
- The top level holds the arrays, tag compare, word select and byte merge.

Test Plan:
- Cold load to 0x1234 with pmem returning line 0x...0 to 0x...7 per word -> pmem_read at 0x1230; after fill, dmem_resp with dmem_rdata = word 2; no pmem_write.
- Load hit 0x1236 immediately after -> dmem_resp in the same cycle, word 3, pmem idle.
- Store 0xBEEF be=11 to 0x1230, then load 0x1230 -> reads 0xBEEF. Then load 0x1A30 (same index 3, different tag) -> pmem_write at 0x1230 containing 0xBEEF, then pmem_read at 0x1A30.
- Store byte be=10 wdata 0xAB00 to 0x1231 on a resident line holding 0x1122 -> the word becomes 0xAB22; the line is marked dirty.
- Drop stb/cyc in the second cycle of a FILL -> pmem_read stays high until pmem_resp, the line is installed, no dmem_resp; a later request to that line hits.
- Assert reset during WRITEBACK -> the next cycle shows IDLE, pmem_write = 0, dmem_resp = 0; a subsequent load to the previously resident line misses.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types for the L1 data cache: line/address field types, FSM states
// and the store byte-merge helper.
package dcache_pkg;

  localparam int DC_NUM_SETS = 8;
  localparam int DC_OFFSET_W = 4;
  localparam int DC_INDEX_W  = $clog2(DC_NUM_SETS);
  localparam int DC_TAG_W    = 16 - DC_INDEX_W - DC_OFFSET_W;

  typedef logic [127:0]            lc3b_cache_line;
  typedef logic [DC_OFFSET_W-1:0]  lc3b_c_offset;
  typedef logic [DC_INDEX_W-1:0]   lc3b_c_index;
  typedef logic [DC_TAG_W-1:0]     lc3b_c_tag;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } dcache_state_e;

  // Byte lanes of new_word arrive already positioned; be selects which land.
  function automatic logic [15:0] merge_bytes(input logic [15:0] old_word,
                                              input logic [15:0] new_word,
                                              input logic [1:0]  be);
    logic [15:0] r;
    r = old_word;
    if (be[0]) r[7:0]  = new_word[7:0];
    if (be[1]) r[15:8] = new_word[15:8];
    return r;
  endfunction

endpackage

// File: rtl/dcache_control.sv
// Miss-handling FSM: sequences optional writeback then fill over the pmem
// handshake. pmem strobes and address select are registered with the state.
module dcache_control
  import dcache_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_valid_i,
  input  logic hit_i,
  input  logic victim_dirty_i,
  input  logic pmem_resp_i,
  output logic pmem_read_o,
  output logic pmem_write_o,
  output logic load_line_o,
  output logic clear_dirty_o,
  output logic addr_sel_victim_o,
  output logic in_idle_o
);

  dcache_state_e state_q;
  logic          pmem_read_q;
  logic          pmem_write_q;
  logic          addr_sel_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pmem_read_q  <= 1'b0;
      pmem_write_q <= 1'b0;
      addr_sel_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && !hit_i) begin
            if (victim_dirty_i) begin
              state_q      <= WRITEBACK;
              pmem_write_q <= 1'b1;
              addr_sel_q   <= 1'b1;
            end else begin
              state_q     <= FILL;
              pmem_read_q <= 1'b1;
              addr_sel_q  <= 1'b0;
            end
          end
        end
        WRITEBACK: begin
          // The writeback always completes; only then is the request re-checked.
          if (pmem_resp_i) begin
            pmem_write_q <= 1'b0;
            addr_sel_q   <= 1'b0;
            if (req_valid_i) begin
              state_q     <= FILL;
              pmem_read_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        FILL: begin
          if (pmem_resp_i) begin
            pmem_read_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q      <= IDLE;
          pmem_read_q  <= 1'b0;
          pmem_write_q <= 1'b0;
          addr_sel_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_read_o       = pmem_read_q;
  assign pmem_write_o      = pmem_write_q;
  assign addr_sel_victim_o = addr_sel_q;
  assign in_idle_o         = (state_q == IDLE);
  assign load_line_o       = (state_q == FILL) && pmem_resp_i;
  assign clear_dirty_o     = (state_q == WRITEBACK) && pmem_resp_i;

endmodule

// File: rtl/dcache.sv
// Direct-mapped write-back, write-allocate L1 data cache: per-set state,
// tag compare, word select and byte merge around the dcache_control FSM.
module dcache
  import dcache_pkg::*;
#(
  parameter int NUM_SETS   = 8,
  parameter int LINE_BYTES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dmem_action_stb,
  input  logic                 dmem_action_cyc,
  input  logic                 dmem_write,
  input  logic [1:0]           dmem_byte_enable,
  input  logic [15:0]          dmem_address,
  input  logic [15:0]          dmem_wdata,
  output logic [15:0]          dmem_rdata,
  output logic                 dmem_resp,
  output logic [15:0]          pmem_address,
  output logic                 pmem_read,
  output logic                 pmem_write,
  output lc3b_cache_line       pmem_wdata,
  input  lc3b_cache_line       pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int OFFSET_W = $clog2(LINE_BYTES);
  localparam int WSEL_W   = $clog2(LINE_BYTES / 2);
  localparam int INDEX_W  = $clog2(NUM_SETS);
  localparam int TAG_W    = 16 - OFFSET_W - INDEX_W;

  logic                 req_valid;
  logic                 hit;
  logic                 victim_dirty;
  logic                 resp;
  logic                 store_update;
  logic                 load_line;
  logic                 clear_dirty;
  logic                 addr_sel_victim;
  logic                 in_idle;
  logic [INDEX_W-1:0]   req_index;
  logic [TAG_W-1:0]     req_tag;
  logic [WSEL_W-1:0]    req_word;
  logic [WSEL_W+3:0]    word_lsb;
  logic [NUM_SETS-1:0]  valid_vec;
  logic [NUM_SETS-1:0]  dirty_vec;
  logic [TAG_W-1:0]     tag_arr  [NUM_SETS];
  lc3b_cache_line       line_arr [NUM_SETS];
  lc3b_cache_line       cur_line;
  lc3b_cache_line       merged_line;
  logic [15:0]          cur_word;
  logic                 unused_addr_bit;

  assign unused_addr_bit = dmem_address[0];

  assign req_valid = dmem_action_stb && dmem_action_cyc;
  assign req_word  = dmem_address[OFFSET_W-1:1];
  assign req_index = dmem_address[OFFSET_W +: INDEX_W];
  assign req_tag   = dmem_address[15 -: TAG_W];
  assign word_lsb  = {req_word, 4'b0000};

  assign cur_line     = line_arr[req_index];
  assign cur_word     = cur_line[word_lsb +: 16];
  assign hit          = valid_vec[req_index] && (tag_arr[req_index] == req_tag);
  assign victim_dirty = valid_vec[req_index] && dirty_vec[req_index];

  // Hits complete combinationally; reset suppresses any response.
  assign resp         = !reset && in_idle && req_valid && hit;
  assign store_update = resp && dmem_write && (dmem_byte_enable != 2'b00);

  always_comb begin
    merged_line = cur_line;
    merged_line[word_lsb +: 16] = merge_bytes(cur_word, dmem_wdata, dmem_byte_enable);
  end

  for (genvar gi = 0; gi < NUM_SETS; gi++) begin : g_set
    logic                valid_q;
    logic                dirty_q;
    logic [TAG_W-1:0]    tag_q;
    lc3b_cache_line      line_q;
    logic                sel;

    assign sel = (req_index == INDEX_W'(gi));

    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q <= 1'b0;
        dirty_q <= 1'b0;
        tag_q   <= '0;
        line_q  <= '0;
      end else if (sel) begin
        if (load_line) begin
          valid_q <= 1'b1;
          dirty_q <= 1'b0;
          tag_q   <= req_tag;
          line_q  <= pmem_rdata;
        end else if (clear_dirty) begin
          dirty_q <= 1'b0;
        end else if (store_update) begin
          line_q  <= merged_line;
          dirty_q <= 1'b1;
        end
      end
    end

    assign valid_vec[gi] = valid_q;
    assign dirty_vec[gi] = dirty_q;
    assign tag_arr[gi]   = tag_q;
    assign line_arr[gi]  = line_q;
  end

  dcache_control u_control (
    .clk               (clk),
    .reset             (reset),
    .req_valid_i       (req_valid),
    .hit_i             (hit),
    .victim_dirty_i    (victim_dirty),
    .pmem_resp_i       (pmem_resp),
    .pmem_read_o       (pmem_read),
    .pmem_write_o      (pmem_write),
    .load_line_o       (load_line),
    .clear_dirty_o     (clear_dirty),
    .addr_sel_victim_o (addr_sel_victim),
    .in_idle_o         (in_idle)
  );

  // Writeback targets the resident line; fill targets the current request.
  assign pmem_address = {(addr_sel_victim ? tag_arr[req_index] : req_tag),
                         req_index, {OFFSET_W{1'b0}}};
  assign pmem_wdata   = cur_line;
  assign dmem_resp    = resp;
  assign dmem_rdata   = resp ? cur_word : 16'h0000;

endmodule
